// File: rtl/segment7_pkg.sv
// rtl/segment7_pkg.sv - shared glyph table and FSM state type for 7-segment capture
//
// Holds the active-low segment patterns ({g,f,e,d,c,b,a}, bit 0 = a) for
// hex digits 0..F, the all-off blank pattern, and the capture FSM states.
package segment7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index i holds the pattern that displays nibble i.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/segment7_decode.sv
// rtl/segment7_decode.sv - combinational segment pattern to hex nibble decoder
//
// Ports:
//   seg_i       7-bit active-low segment pattern {g,f,e,d,c,b,a}
//   nibble_o    decoded hex value (0 when not a glyph)
//   is_glyph_o  pattern is one of the 16 hex glyphs
//   is_blank_o  pattern is all segments off
module segment7_decode
    import segment7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       is_glyph_o,
    output logic       is_blank_o
);

    always_comb begin
        nibble_o   = 4'h0;
        is_glyph_o = 1'b0;
        is_blank_o = (seg_i == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_GLYPH[i]) begin
                nibble_o   = 4'(i);
                is_glyph_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/segment7_capture.sv
// rtl/segment7_capture.sv - passive monitor decoding a multiplexed 7-segment display bus
//
// Watches active-low digit selects and shared segment lines, filters scan
// transitions and glitches, decodes stable patterns back to hex and
// assembles complete frames.
// Optional macro SEGMENT7_CAPTURE_SYNC_EN: adds a two-flop synchronizer on
// an/seg ahead of the input register (+2 cycles latency).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   an           digit selects, active 0
//   seg          segments {g,f,e,d,c,b,a}, active 0
//   value        last complete frame, digit 0 in bits [3:0]
//   digit_valid  digit decoded since the last timeout
//   blank        digit was captured all-off
//   update       one-cycle pulse when value is reloaded
//   err          one-cycle pulse when a stable pattern is not a legal glyph
//   stale        no complete frame within TIMEOUT_CYCLES
module segment7_capture
    import segment7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    update,
    output logic                    err,
    output logic                    stale
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = NUM_DIGITS + 7;

    logic [NUM_DIGITS-1:0] an_s;
    logic [6:0]            seg_s;

`ifdef SEGMENT7_CAPTURE_SYNC_EN
    logic [NUM_DIGITS-1:0] an_m1_q, an_m2_q;
    logic [6:0]            seg_m1_q, seg_m2_q;

    // Reset to all ones so the bus looks inactive until real samples arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m1_q  <= '1;
            an_m2_q  <= '1;
            seg_m1_q <= '1;
            seg_m2_q <= '1;
        end else begin
            an_m1_q  <= an;
            an_m2_q  <= an_m1_q;
            seg_m1_q <= seg;
            seg_m2_q <= seg_m1_q;
        end
    end

    assign an_s  = an_m2_q;
    assign seg_s = seg_m2_q;
`else
    assign an_s  = an;
    assign seg_s = seg;
`endif

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic [SW-1:0]         prev_q;
    cap_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  accept;

    logic [NUM_DIGITS-1:0][3:0] digit_q;
    logic [4*NUM_DIGITS-1:0]    value_q;
    logic [NUM_DIGITS-1:0]      valid_q, blank_q, seen_q;
    logic                       update_q, err_q, stale_q;
    logic [TW-1:0]              timer_q;

    logic          legal, changed, frame_done, timeout_hit;
    logic [IW-1:0] idx;
    int unsigned   n_sel;
    logic [3:0]    nibble;
    logic          is_glyph, is_blank;

    // A sample is legal only when exactly one digit select is driven low.
    always_comb begin
        n_sel = 0;
        idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                n_sel = n_sel + 1;
                idx   = IW'(i);
            end
        end
    end

    assign legal   = (n_sel == 1);
    assign changed = ({an_q, seg_q} != prev_q);

    segment7_decode u_decode (
        .seg_i      (seg_q),
        .nibble_o   (nibble),
        .is_glyph_o (is_glyph),
        .is_blank_o (is_blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q    <= '1;
            seg_q   <= '1;
            prev_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            an_q    <= an_s;
            seg_q   <= seg_s;
            prev_q  <= {an_q, seg_q};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The cycle a new legal sample first appears counts as stable sample 0,
    // so acceptance fires on the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        accept  = 1'b0;
        if (!legal) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = TRACK;
                TRACK: begin
                    if (!changed) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CW'(STABLE_CYCLES - 1)) begin
                            accept  = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD:    if (changed) state_d = TRACK;
                default: state_d = IDLE;
            endcase
        end
    end

    assign frame_done  = &seen_q;
    assign timeout_hit = !frame_done && (timer_q == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q  <= '0;
            value_q  <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            seen_q   <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b1;
            timer_q  <= '0;
        end else begin
            update_q <= frame_done;
            err_q    <= accept && !is_glyph && !is_blank;
            if (frame_done) begin
                value_q <= digit_q;
                seen_q  <= '0;
                timer_q <= '0;
                stale_q <= 1'b0;
            end else if (timer_q != TW'(TIMEOUT_CYCLES - 1)) begin
                timer_q <= timer_q + 1'b1;
                if (timeout_hit) begin
                    stale_q <= 1'b1;
                    valid_q <= '0;
                    seen_q  <= '0;
                end
            end
            // Placed last so a digit accepted on the timeout edge survives it.
            if (accept && (is_glyph || is_blank)) begin
                digit_q[idx] <= is_glyph ? nibble : 4'h0;
                blank_q[idx] <= is_blank;
                valid_q[idx] <= 1'b1;
                seen_q[idx]  <= 1'b1;
            end
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign blank       = blank_q;
    assign update      = update_q;
    assign err         = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_segment7_capture.sv
// tb/tb_segment7_capture.sv - self-checking bench for segment7_capture
module tb_segment7_capture;

    localparam int ND = 4;
    localparam int SC = 4;
    localparam int TO = 64;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BADG  = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] value;
    logic [3:0]  digit_valid, blank;
    logic        update, err, stale;

    segment7_capture #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .value       (value),
        .digit_valid (digit_valid),
        .blank       (blank),
        .update      (update),
        .err         (err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    bit running = 1'b1;

    // Model state: pin history window plus the frame-level bookkeeping.
    logic [15:0] m_value;
    logic [3:0]  m_valid, m_blank, m_seen;
    logic [3:0]  m_digit [4];
    logic        m_upd, m_err, m_stale;
    int          m_since;
    logic [10:0] h [5];
    int          hn;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0..15 glyph, 16 blank, 17 not a glyph
    function automatic int decode(input logic [6:0] s);
        if (s == BLANK) return 16;
        for (int i = 0; i < 16; i++) if (s == glyph[i]) return i;
        return 17;
    endfunction

    function automatic int sel_index(input logic [3:0] a);
        int k;
        k = -1;
        if ($countones(~a) != 1) return -1;
        for (int i = 0; i < 4; i++) if (!a[i]) k = i;
        return k;
    endfunction

    task automatic m_reset();
        m_value = '0; m_valid = '0; m_blank = '0; m_seen = '0;
        for (int i = 0; i < 4; i++) m_digit[i] = '0;
        m_upd = 0; m_err = 0; m_stale = 1; m_since = 0; hn = 0;
        for (int i = 0; i < 5; i++) h[i] = '1;
    endtask

    // One clock of the model. A digit is taken when the four most recent
    // samples before this edge are one identical legal selection and the
    // sample before them differed (or did not exist since reset).
    task automatic model_step();
        bit acc;
        int d, g;
        acc = (hn >= SC) && (h[0] == h[1]) && (h[1] == h[2]) && (h[2] == h[3])
              && ((hn == SC) || (h[4] != h[0]));
        d = sel_index(h[0][10:7]);
        g = decode(h[0][6:0]);
        if (d < 0) acc = 0;
        m_err = 0;
        m_upd = (m_seen == 4'hF);
        if (m_upd) begin
            m_value = {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
            m_seen = '0; m_since = 0; m_stale = 0;
        end else if (m_since < TO - 1) begin
            m_since++;
            if (m_since == TO - 1) begin
                m_stale = 1; m_valid = '0; m_seen = '0;
            end
        end
        if (acc) begin
            if (g == 17) m_err = 1;
            else begin
                m_digit[d] = (g == 16) ? 4'h0 : 4'(g);
                m_blank[d] = (g == 16);
                m_valid[d] = 1'b1;
                m_seen[d]  = 1'b1;
            end
        end
        for (int i = 4; i > 0; i--) h[i] = h[i-1];
        h[0] = {an, seg};
        if (hn < 1000) hn++;
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (running) begin
                if (!rst_n) m_reset();
                else model_step();
                chk("value", value, m_value);
                chk("digit_valid", 16'(digit_valid), 16'(m_valid));
                chk("blank", 16'(blank), 16'(m_blank));
                chk("update", 16'(update), 16'(m_upd));
                chk("err", 16'(err), 16'(m_err));
                chk("stale", 16'(stale), 16'(m_stale));
                if (update === 1'b1) upd_cnt++;
                if (err === 1'b1) err_cnt++;
            end
        end
    end

    task automatic step(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        #1;
        an = a;
        seg = s;
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        logic [3:0] a;
        a = ~(4'b0001 << d);
        repeat (n) step(a, s);
    endtask

    task automatic frame(input logic [6:0] g0, input logic [6:0] g1,
                         input logic [6:0] g2, input logic [6:0] g3, input int n);
        show(0, g0, n);
        show(1, g1, n);
        show(2, g2, n);
        show(3, g3, n);
        repeat (2) step(4'hF, 7'h7F);
    endtask

    int upd_base;

    initial begin
        repeat (3) step(4'hF, 7'h7F);
        rst_n = 1'b1;
        chk("rst_value", value, 16'h0000);
        chk("rst_stale", 16'(stale), 16'h1);
        chk("rst_valid", 16'(digit_valid), 16'h0);

        // Frame decode 1,2,3,4
        frame(glyph[4], glyph[3], glyph[2], glyph[1], 8);
        chk("f1_value", value, 16'h1234);
        chk("f1_valid", 16'(digit_valid), 16'hF);
        chk("f1_stale", 16'(stale), 16'h0);
        chk("f1_updates", 16'(upd_cnt), 16'd1);

        // Glitch of 8's pattern on digit 1
        show(0, glyph[4], 8);
        show(1, glyph[3], 4);
        show(1, glyph[8], 2);
        show(1, glyph[3], 8);
        show(2, glyph[2], 8);
        show(3, glyph[1], 8);
        repeat (2) step(4'hF, 7'h7F);
        chk("glitch_value", value, 16'h1234);
        chk("glitch_updates", 16'(upd_cnt), 16'd2);
        chk("glitch_err", 16'(err_cnt), 16'd0);

        // Two selects low
        repeat (20) step(4'b1100, glyph[5]);
        chk("illsel_updates", 16'(upd_cnt), 16'd2);
        chk("illsel_valid", 16'(digit_valid), 16'hF);
        chk("illsel_err", 16'(err_cnt), 16'd0);

        // Illegal glyph on digit 2, then repaired
        frame(glyph[4], glyph[3], BADG, glyph[1], 6);
        chk("badg_err", 16'(err_cnt), 16'd1);
        chk("badg_updates", 16'(upd_cnt), 16'd2);
        show(2, glyph[2], 6);
        repeat (2) step(4'hF, 7'h7F);
        chk("fix_updates", 16'(upd_cnt), 16'd3);
        chk("fix_value", value, 16'h1234);

        // Blank digit 3 then timeout
        frame(glyph[12], glyph[11], glyph[10], BLANK, 8);
        chk("blank_value", value, 16'h0ABC);
        chk("blank_flags", 16'(blank), 16'h8);
        chk("blank_updates", 16'(upd_cnt), 16'd4);
        repeat (TO + 6) step(4'hF, 7'h7F);
        chk("to_stale", 16'(stale), 16'h1);
        chk("to_valid", 16'(digit_valid), 16'h0);
        chk("to_value", value, 16'h0ABC);
        chk("to_updates", 16'(upd_cnt), 16'd4);

        // Reset mid-frame
        show(0, glyph[5], 8);
        show(1, glyph[6], 8);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_value", value, 16'h0000);
        chk("mrst_valid", 16'(digit_valid), 16'h0);
        chk("mrst_blank", 16'(blank), 16'h0);
        chk("mrst_stale", 16'(stale), 16'h1);
        upd_base = upd_cnt;
        frame(glyph[7], glyph[8], glyph[9], glyph[0], 8);
        chk("mrst_frame_value", value, 16'h0987);
        chk("mrst_updates", 16'(upd_cnt - upd_base), 16'd1);

        @(negedge clk);
        #1;
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segment7_capture.md
Name: segment7_capture

Overview:
- Passive monitor for a multiplexed, active-low 4-digit 7-segment display bus (digit selects plus shared segment lines).
- Performs the reverse of the hex-to-segment translation: it watches the bus, filters scan transitions and glitches, and decodes each stable segment pattern back to a hex nibble.
- Assembles a full frame value with per-digit valid and blank flags.
- Used on-chip for display self-check and by testbenches as a display scoreboard.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; value width is 4*NUM_DIGITS.
- STABLE_CYCLES, 4, consecutive identical legal samples required to accept a digit; minimum 2.
- TIMEOUT_CYCLES, 65536, clocks without a completed frame before all data is declared stale.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- an  in  NUM_DIGITS  digit selects, active 0.
- seg  in  7  segments {g,f,e,d,c,b,a}, bit 0 = a, active 0.
- value  out  4*NUM_DIGITS  last complete frame; digit 0 in bits [3:0].
- digit_valid  out  NUM_DIGITS  digit decoded since the last timeout.
- blank  out  NUM_DIGITS  digit was captured all-off (7'b1111111).
- update  out  1  one-cycle pulse when value is reloaded.
- err  out  1  one-cycle pulse when a stable pattern is not a legal glyph.
- stale  out  1  no complete frame within TIMEOUT_CYCLES.

Behaviour:
- Reset state: value 0, digit_valid 0, blank 0, update 0, err 0, stale 1; FSM in IDLE; all counters 0.
- Input stage: an and seg are registered once into an_q and seg_q.
- Legal sample: exactly one bit of an_q is 0. idx is the position of that bit.
- FSM states:
  - IDLE: sample not legal; stab_cnt held at 0.
  - TRACK: legal sample; stab_cnt increments while {an_q,seg_q} is unchanged and restarts at 0 on any change.
  - HOLD: digit accepted; stays here while the sample is unchanged.
- Transitions:
  - IDLE to TRACK on a legal sample.
  - TRACK to HOLD when stab_cnt reaches STABLE_CYCLES-1 (the accept cycle).
  - TRACK or HOLD to IDLE on an illegal sample.
  - HOLD to TRACK with stab_cnt=0 on a changed legal sample.
- Latency: a digit is registered STABLE_CYCLES+1 clocks after its pattern first appears on the pins.
- Glyph table (seg value, nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0011000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
- Accept outcomes:
  - Legal glyph: digit_reg[idx] <= nibble; blank[idx] <= 0; digit_valid[idx] <= 1; seen[idx] <= 1.
  - 1111111: digit_reg[idx] <= 0; blank[idx] <= 1; digit_valid[idx] <= 1; seen[idx] <= 1.
  - Any other pattern: err pulses for one cycle; digit registers, flags and seen are left unchanged.
- Frame completion:
  - The cycle after seen becomes all ones: value <= concatenated digit_reg, update=1 for one cycle, seen <= 0, frame timer <= 0, stale <= 0.
  - At most one accept occurs per cycle, so frame completion never collides with a second accept.
- Timeout: the frame timer counts every cycle without an update. When it reaches TIMEOUT_CYCLES-1:
  - stale <= 1, digit_valid <= 0, seen <= 0;
  - value is retained;
  - the timer saturates.
- A digit re-accepted before the frame completes overwrites its digit_reg (last stable pattern wins).
- Reset asserted mid-frame discards partial digits immediately. No update is produced until a full new frame is seen.

Optional Feature:
- Macro: SEGMENT7_CAPTURE_SYNC_EN.
- Defined: an and seg pass through a two-flop synchronizer ahead of the an_q/seg_q register. This adds 2 cycles to all latencies. Required when the display bus comes from another clock domain or from pins. Synchronizer flops reset to 1 (inactive).
- Undefined: the single input register only; inputs must be synchronous to clk.

Decomposition:
- Package segment7_pkg holds:
  - the 16 glyph constants and the blank constant 7'b1111111;
  - FSM state typedef (IDLE/TRACK/HOLD).
- Sub-module segment7_decode: combinational seg to {nibble, is_glyph, is_blank}. It is reusable by other display checkers.

Test Plan:
- Frame decode: drive digits 3..0 = glyphs 1,2,3,4, each held 8 cycles, scanned in order -> one update pulse; value=16'h1234; digit_valid=4'hF; stale=0.
- Glitch filter: mid-scan, a 2-cycle pulse of 8's pattern (0000000) on digit 1 -> no accept and no err; next frame value is unchanged at 16'h1234.
- Illegal select: an=4'b1100 with glyph 5 held 20 cycles -> no accept; FSM stays in IDLE.
- Illegal glyph: seg=7'b1010101 stable on digit 2 -> exactly one err pulse; digit_reg[2] unchanged; no update until digit 2 later shows a legal glyph.
- Blank and timeout: digit 3 blank, digits 2..0 = A,b,C -> value=16'h0ABC with blank=4'b1000. Then stop scanning for TIMEOUT_CYCLES (set to 64) -> stale=1, digit_valid=0, value held at 16'h0ABC.
- Reset mid-frame: accept digits 0 and 1, assert rst_n low for 1 cycle -> all outputs return to reset values. The following complete frame produces exactly one update.
